// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN feature-map pipeline stages.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    // Wide enough that any supported pixel width sign-extends into it losslessly.
    localparam int SMAX_WIDTH = 64;

    typedef struct packed {
        int unsigned width;
        int unsigned height;
    } fmap_dims_t;

    localparam fmap_dims_t CONV1_OUT = '{width: 28, height: 28};
    localparam fmap_dims_t POOL1_OUT = '{width: 14, height: 14};
    localparam fmap_dims_t CONV2_OUT = '{width: 10, height: 10};
    localparam fmap_dims_t POOL2_OUT = '{width: 5, height: 5};

    function automatic int cnt_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic logic signed [SMAX_WIDTH-1:0] smax(
        input logic signed [SMAX_WIDTH-1:0] a,
        input logic signed [SMAX_WIDTH-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for horizontal pair maxima of even rows: synchronous write,
// asynchronous read, one shared address.
module pool_line_buf #(
    parameter int data_width = 16,
    parameter int depth      = 14,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [addr_width-1:0] i_addr,
    input  logic [data_width-1:0] i_wr_data,
    output logic [data_width-1:0] o_rd_data
);

    logic [data_width-1:0] r_mem [depth];

    // No reset: contents are always rewritten by an even row before being read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_addr];

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order single-channel frame.
module maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int img_width  = 28,
    parameter int img_height = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [data_width-1:0] d_in,
    output logic [data_width-1:0] d_out,
    output logic                  out_valid,
    output logic                  frame_done
);

    localparam int  POOL_W   = img_width / 2;
    localparam int  COL_W    = (img_width > 2) ? $clog2(img_width) : 2;
    localparam int  ROW_W    = cnt_width(img_height);
    localparam int  ADDR_W   = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam bit  ODD_W    = (img_width % 2) != 0;
    // With an odd height the frame ends on a truncated row, so the pulse
    // follows the very last pixel instead of the last window.
    localparam int  DONE_COL = (img_height % 2 != 0) ? img_width - 1 : 2 * POOL_W - 1;

    logic [COL_W-1:0]             r_col;
    logic [ROW_W-1:0]             r_row;
    logic signed [data_width-1:0] r_pair;

    logic                         w_colLast;
    logic                         w_rowLast;
    logic                         w_pairLoad;
    logic                         w_pairStep;
    logic                         w_bufWrite;
    logic                         w_windowDone;
    logic                         w_frameDone;
    logic [ADDR_W-1:0]            w_addr;
    logic [data_width-1:0]        w_lineRd;
    logic signed [SMAX_WIDTH-1:0] w_pairExt;
    logic signed [SMAX_WIDTH-1:0] w_inExt;
    logic signed [SMAX_WIDTH-1:0] w_pairMaxExt;
    logic signed [SMAX_WIDTH-1:0] w_lineExt;
    logic                         w_pairKeep;
    logic                         w_lineKeep;
    logic signed [data_width-1:0] w_pairMax;
    logic signed [data_width-1:0] w_poolMax;

    assign w_colLast    = (r_col == COL_W'(img_width - 1));
    assign w_rowLast    = (r_row == ROW_W'(img_height - 1));
    assign w_pairLoad   = in_valid & ~r_col[0] & ~(ODD_W & w_colLast);
    assign w_pairStep   = in_valid & r_col[0];
    assign w_bufWrite   = w_pairStep & ~r_row[0];
    assign w_windowDone = w_pairStep & r_row[0];
    assign w_frameDone  = in_valid & w_rowLast & (r_col == COL_W'(DONE_COL));
    assign w_addr       = ADDR_W'(r_col >> 1);

    assign w_pairExt    = SMAX_WIDTH'(r_pair);
    assign w_inExt      = SMAX_WIDTH'($signed(d_in));
    assign w_pairKeep   = (smax(w_pairExt, w_inExt) == w_pairExt);
    assign w_pairMax    = w_pairKeep ? r_pair : $signed(d_in);

    assign w_pairMaxExt = SMAX_WIDTH'(w_pairMax);
    assign w_lineExt    = SMAX_WIDTH'($signed(w_lineRd));
    assign w_lineKeep   = (smax(w_lineExt, w_pairMaxExt) == w_lineExt);
    assign w_poolMax    = w_lineKeep ? $signed(w_lineRd) : w_pairMax;

    pool_line_buf #(
        .data_width (data_width),
        .depth      (POOL_W),
        .addr_width (ADDR_W)
    ) u_lineBuf (
        .clk       (clk),
        .i_wr_en   (w_bufWrite),
        .i_addr    (w_addr),
        .i_wr_data (w_pairMax),
        .o_rd_data (w_lineRd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_colLast) begin
                r_col <= '0;
                r_row <= w_rowLast ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair <= '0;
        end else if (w_pairLoad) begin
            r_pair <= $signed(d_in);
        end
    end

    // d_out keeps the last pooled value between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= w_windowDone;
            frame_done <= w_frameDone;
            if (w_windowDone) begin
                d_out <= w_poolMax;
            end
        end
    end

endmodule
